// File: rtl/imem_dmem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// imem_dmem_port_arbiter_if
//   Bundles the fetch, load/store and memory-side signals of the shared
//   memory port arbiter.
//   Signal names carry the arbiter's point of view (_i = into the arbiter,
//   _o = out of the arbiter).
//   slave  : the arbiter itself
//   master : IF stage + LSU + memory (the environment around the arbiter)
// ----------------------------------------------------------------------------
interface imem_dmem_port_arbiter_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 16
);
    // fetch side
    logic                      if_req_i;
    logic [MEM_ADDR_WIDTH-1:0] if_addr_i;
    logic                      if_flush_i;
    logic                      if_gnt_o;
    logic                      if_stall_o;
    logic                      if_valid_o;
    logic [DATA_WIDTH-1:0]     if_rdata_o;
    // load/store side
    logic                      ls_req_i;
    logic                      ls_we_i;
    logic [DATA_WIDTH/8-1:0]   ls_be_i;
    logic [MEM_ADDR_WIDTH-1:0] ls_addr_i;
    logic [DATA_WIDTH-1:0]     ls_wdata_i;
    logic                      ls_gnt_o;
    logic                      ls_valid_o;
    logic [DATA_WIDTH-1:0]     ls_rdata_o;
    // memory side
    logic                      mem_en_o;
    logic                      mem_we_o;
    logic [DATA_WIDTH/8-1:0]   mem_be_o;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0]     mem_wdata_o;
    logic [DATA_WIDTH-1:0]     mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i, if_flush_i,
        output if_gnt_o, if_stall_o, if_valid_o, if_rdata_o,
        input  ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
        output ls_gnt_o, ls_valid_o, ls_rdata_o,
        output mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output if_req_i, if_addr_i, if_flush_i,
        input  if_gnt_o, if_stall_o, if_valid_o, if_rdata_o,
        output ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
        input  ls_gnt_o, ls_valid_o, ls_rdata_o,
        input  mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/imem_dmem_port_arbiter.sv
// ----------------------------------------------------------------------------
// imem_dmem_port_arbiter
//   Shares one single-port, fixed-latency, pipelined memory between the
//   instruction fetch stage and the load/store unit. One access per cycle;
//   the LSU has priority, but fetch is guaranteed a grant after STARVE_LIMIT
//   consecutive LSU grants. A tag pipeline of MEM_LATENCY stages routes each
//   read response to its owner; a flush kills in-flight fetch responses.
//
//   Ports:
//     clk  - clock, all state on the rising edge
//     rst  - synchronous active-high reset
//     bus  - imem_dmem_port_arbiter_if.slave (fetch, LSU and memory signals)
// ----------------------------------------------------------------------------
module imem_dmem_port_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int MEM_LATENCY    = 1,
    parameter int STARVE_LIMIT   = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    imem_dmem_port_arbiter_if.slave   bus
);

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    localparam int            CW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);
    localparam int            TAIL       = MEM_LATENCY - 1;

    logic [CW-1:0]          starve_q, starve_d;
    logic [MEM_LATENCY-1:0] tag_vld_q, tag_vld_d;
    owner_e                 tag_own_q [MEM_LATENCY];
    owner_e                 tag_own_d [MEM_LATENCY];

    logic   if_gnt;
    logic   ls_gnt;
    logic   rd_push;
    owner_e rd_own;

    // Grant: LSU first unless fetch has waited STARVE_LIMIT LSU grants.
    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (!rst) begin
            if (bus.ls_req_i && !(bus.if_req_i && (starve_q == STARVE_MAX))) begin
                ls_gnt = 1'b1;
            end else if (bus.if_req_i) begin
                if_gnt = 1'b1;
            end
        end
    end

    assign bus.if_gnt_o    = if_gnt;
    assign bus.ls_gnt_o    = ls_gnt;
    assign bus.if_stall_o  = bus.if_req_i & ~if_gnt;
    assign bus.mem_en_o    = if_gnt | ls_gnt;
    assign bus.mem_we_o    = ls_gnt & bus.ls_we_i;
    assign bus.mem_be_o    = ls_gnt ? bus.ls_be_i : (if_gnt ? '1 : '0);
    assign bus.mem_addr_o  = ls_gnt ? bus.ls_addr_i : bus.if_addr_i;
    assign bus.mem_wdata_o = bus.ls_wdata_i;
    assign bus.if_rdata_o  = bus.mem_rdata_i;
    assign bus.ls_rdata_o  = bus.mem_rdata_i;

    // The tail tag is killed by a same-cycle flush, so its fetch valid is
    // gated here rather than waiting for the register update.
    assign bus.ls_valid_o = ~rst & tag_vld_q[TAIL] & (tag_own_q[TAIL] == OWN_LS);
    assign bus.if_valid_o = ~rst & tag_vld_q[TAIL] & (tag_own_q[TAIL] == OWN_IF)
                            & ~bus.if_flush_i;

    always_comb begin
        starve_d  = '0;
        tag_vld_d = '0;
        for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
            tag_own_d[i] = OWN_IF;
        end
        rd_push = if_gnt | (ls_gnt & ~bus.ls_we_i);
        rd_own  = ls_gnt ? OWN_LS : OWN_IF;

        if (ls_gnt && bus.if_req_i) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
        end

        // Head takes the new read (a fetch granted during a flush survives);
        // older stages shift toward the tail with IF tags killed on flush.
        tag_vld_d[0] = rd_push;
        tag_own_d[0] = rd_own;
        for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1]
                           & ~(bus.if_flush_i & (tag_own_q[i-1] == OWN_IF));
            tag_own_d[i] = tag_own_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q  <= '0;
            tag_vld_q <= '0;
        end else begin
            starve_q  <= starve_d;
            tag_vld_q <= tag_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
            tag_own_q[i] <= tag_own_d[i];
        end
    end

endmodule

// File: doc/imem_dmem_port_arbiter.md
# imem_dmem_port_arbiter

Shares one single-port, fixed-latency, pipelined memory between the instruction-fetch stage and the load/store unit. Each cycle it picks at most one requester and drives the memory port. It tracks in-flight reads so responses return to the right owner, and produces the fetch stall. Fetch responses in flight are discarded on a branch/jump flush. It sits between the core's IF stage / LSU and the unified memory.

## Interface
- `DATA_WIDTH`, 32, data/word width.
- `MEM_ADDR_WIDTH`, 16, memory address width.
- `MEM_LATENCY`, 1, cycles from request issue to `mem_rdata_i` valid; legal range 1..4.
- `STARVE_LIMIT`, 3, max consecutive LSU grants while fetch waits; legal range 1..15.

Ports:
- `clk` in 1 — single clock; all state on rising edge.
- `rst` in 1 — reset is synchronous and active-high.
- `if_req_i` in 1 — fetch request.
- `if_addr_i` in MEM_ADDR_WIDTH — fetch address.
- `if_flush_i` in 1 — branch/jump taken; kill in-flight fetch responses.
- `if_gnt_o` out 1 — fetch granted this cycle.
- `if_stall_o` out 1 — `if_req_i & !if_gnt_o`.
- `if_valid_o` out 1 — fetch read data valid.
- `if_rdata_o` out DATA_WIDTH — fetch read data.
- `ls_req_i` in 1 — LSU request.
- `ls_we_i` in 1 — 1 = write, 0 = read.
- `ls_be_i` in DATA_WIDTH/8 — byte enables, writes only.
- `ls_addr_i` in MEM_ADDR_WIDTH — LSU address.
- `ls_wdata_i` in DATA_WIDTH — write data.
- `ls_gnt_o` out 1 — LSU granted this cycle.
- `ls_valid_o` out 1 — LSU read data valid.
- `ls_rdata_o` out DATA_WIDTH — LSU read data.
- `mem_en_o` out 1 — memory access enable.
- `mem_we_o` out 1 — memory write.
- `mem_be_o` out DATA_WIDTH/8 — memory byte enables.
- `mem_addr_o` out MEM_ADDR_WIDTH — memory address.
- `mem_wdata_o` out DATA_WIDTH — memory write data.
- `mem_rdata_i` in DATA_WIDTH — memory read data, MEM_LATENCY cycles after issue.

## Operation
- Requests are level-held until granted; requesters must keep addr/data stable while `req` is high and `gnt` is low.
- Grant is combinational from current requests and the starve counter. At most one of `if_gnt_o` / `ls_gnt_o` is high.
- Arbitration:
  - Only one requester → it wins.
  - Both requesting → LSU wins, unless `starve_cnt == STARVE_LIMIT`; then fetch wins.
- Starve counter (width fits STARVE_LIMIT):
  - Increments when LSU is granted while `if_req_i` is high.
  - Clears when fetch is granted or `if_req_i` is low.
  - Saturates at STARVE_LIMIT.
- Granted requester's fields are muxed onto `mem_*`; `mem_en_o = if_gnt_o | ls_gnt_o`.
  - Fetch: `mem_we_o = 0`, `mem_be_o` = all ones.
  - With no grant, `mem_we_o` and `mem_be_o` are 0.
- Writes complete at grant; no `ls_valid_o` pulse is produced for writes.
- Tag pipeline: MEM_LATENCY stages of {valid, owner}. A read grant pushes {1, owner = IF/LS}; other cycles push {0, x}. The tail stage selects the response.
  - Tail {1, LS} → `ls_valid_o = 1`.
  - Tail {1, IF}, not killed → `if_valid_o = 1`.
  - Both `rdata` outputs are wired to `mem_rdata_i`.
- Flush: `if_flush_i` clears the valid bit of every in-flight IF-owned tag, including the tail entry in the same cycle; that tail's `if_valid_o` is suppressed combinationally.
  - A fetch granted in the flush cycle is the branch target and is kept.
  - LS tags are never affected by flush.
- Responses return strictly in issue order; there is no backpressure on responses.

## Timing
- Reset (`rst` high at a rising edge):
  - Tag pipeline valid bits and `starve_cnt` cleared.
  - While `rst` is high, all grants, `mem_en_o`, `mem_we_o`, `if_valid_o`, `ls_valid_o` are forced 0, and `if_stall_o = if_req_i`.
- Reset mid-operation drops all in-flight reads; no valid pulse appears for them after reset deasserts.
- Grant at cycle T → `mem_*` driven in T → valid pulse at T+MEM_LATENCY with data = `mem_rdata_i` that cycle.
- Throughput: one access per cycle. Back-to-back reads by either owner are allowed.
- Fetch worst-case wait under continuous LSU traffic: STARVE_LIMIT cycles, then grant.
- A response and a new grant may coincide in the same cycle; they are independent.

## Test plan
1. **Reset values:** `rst`=1 for 2 cycles with both requesting → all grants and valids 0, `if_stall_o`=1. After release, first grant goes to LSU (`starve_cnt`=0).
2. **Fetch only:** `if_req_i` high, addresses 0x0, 0x4, 0x8, MEM_LATENCY=1 → `if_gnt_o` every cycle, `if_valid_o` one cycle later with matching `mem_rdata_i`, `if_stall_o`=0.
3. **Fairness:** both requesting continuously, STARVE_LIMIT=3 → grant pattern LS, LS, LS, IF, LS, LS, LS, IF; `if_stall_o` high exactly on LS cycles.
4. **Flush:** MEM_LATENCY=3, fetch granted at T, T+1; `if_flush_i` at T+2 with new fetch granted at T+2 → no `if_valid_o` at T+3, T+4; `if_valid_o`=1 at T+5.
5. **Mixed traffic:** LS write at T (be=0011, data 0xDEADBEEF), LS read at T+1, fetch at T+2, latency 2 → `mem_we_o`=1 and `mem_be_o`=0011 at T; `ls_valid_o` only at T+3; `if_valid_o` at T+4.
6. **Reset with reads in flight:** `rst` asserted at T+1 with 2 reads in flight, latency 3 → zero valid pulses through T+6.
